dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the CPU memory stage and a debug/DMA engine (UART loader).
- Sequences each access as a held request that completes on a memory ready strobe, so multi-cycle memories and memory-mapped I/O are supported.
- While the CPU waits, the block stalls the pipeline.
- Sits between the memory stage/debug port and the memory/IO bus.

---
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / DMA) arbiter for a single ready-strobed data-memory port.
// Round-robin on ties, sticky error flag when a granted access times out.
module dmem_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_drw,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_drw,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic [31:0] dma_rdata,
   output logic        dma_ack,
   output logic        mem_req,
   output logic        mem_drw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA} state_t;

   state_t          state;
   logic            last_dma;
   logic [TO_W-1:0] cnt;
   logic            timeout;
   logic            grant_cpu;

   // Abort fires only when the final allowed wait cycle passes without ready.
   assign timeout   = (state != IDLE) && !mem_ready && (cnt == TO_W'(TIMEOUT - 1));
   assign cpu_stall = cpu_req && !((state == GNT_CPU) && (mem_ready || timeout));
   assign grant_cpu = cpu_req && (!dma_req || last_dma);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         last_dma  <= 1'b1;
         cnt       <= '0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
         dma_ack   <= 1'b0;
         mem_req   <= 1'b0;
         mem_drw   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
      end else begin
         dma_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_cpu) begin
                  state     <= GNT_CPU;
                  mem_req   <= 1'b1;
                  mem_drw   <= cpu_drw;
                  mem_addr  <= cpu_addr;
                  mem_wdata <= cpu_wdata;
                  last_dma  <= 1'b0;
                  cnt       <= '0;
               end else if (dma_req) begin
                  state     <= GNT_DMA;
                  mem_req   <= 1'b1;
                  mem_drw   <= dma_drw;
                  mem_addr  <= dma_addr;
                  mem_wdata <= dma_wdata;
                  last_dma  <= 1'b1;
                  cnt       <= '0;
               end
            end
            default: begin
               if (mem_ready || timeout) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  if (state == GNT_DMA)
                     dma_ack <= 1'b1;
                  if (mem_ready) begin
                     // Writes leave the requester's read data untouched.
                     if (!mem_drw) begin
                        if (state == GNT_DMA)
                           dma_rdata <= mem_rdata;
                        else
                           cpu_rdata <= mem_rdata;
                     end
                  end else begin
                     err <= 1'b1;
                     if (state == GNT_DMA)
                        dma_rdata <= '0;
                     else
                        cpu_rdata <= '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_dmem_arbiter;
   localparam int TIMEOUT = 16;
   localparam int TO_W    = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_drw;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dma_req, dma_drw;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic        dma_ack;
   logic        mem_req, mem_drw;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        err;

   always #5 clk = ~clk;

   dmem_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_drw(cpu_drw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_drw(dma_drw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_req(mem_req), .mem_drw(mem_drw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: owner 0 = nobody, 1 = CPU, 2 = DMA.
   int          owner;
   int          waited;
   bit          last_dma;
   logic        a_drw;
   logic [31:0] a_addr, a_wdata;
   logic [31:0] m_cpu_rdata, m_dma_rdata;
   bit          m_dma_ack, m_err, m_mem_req;
   bit          cpu_done, dma_done;

   function automatic void model_reset();
      owner = 0; waited = 0; last_dma = 1'b1;
      a_drw = 1'b0; a_addr = '0; a_wdata = '0;
      m_cpu_rdata = '0; m_dma_rdata = '0;
      m_dma_ack = 1'b0; m_err = 1'b0; m_mem_req = 1'b0;
      cpu_done = 1'b0; dma_done = 1'b0;
   endfunction

   // Advances the model across one rising edge using the inputs seen at that edge.
   function automatic void model_step();
      cpu_done = 1'b0; dma_done = 1'b0; m_dma_ack = 1'b0;
      if (!rst) begin
         model_reset();
      end else if (owner == 0) begin
         if (cpu_req && (!dma_req || last_dma)) begin
            owner = 1; a_drw = cpu_drw; a_addr = cpu_addr; a_wdata = cpu_wdata; last_dma = 1'b0;
         end else if (dma_req) begin
            owner = 2; a_drw = dma_drw; a_addr = dma_addr; a_wdata = dma_wdata; last_dma = 1'b1;
         end
         if (owner != 0) begin
            waited = 0; m_mem_req = 1'b1;
         end
      end else if (mem_ready || waited == TIMEOUT - 1) begin
         if (mem_ready) begin
            if (!a_drw) begin
               if (owner == 1) m_cpu_rdata = mem_rdata; else m_dma_rdata = mem_rdata;
            end
         end else begin
            if (owner == 1) m_cpu_rdata = '0; else m_dma_rdata = '0;
            m_err = 1'b1;
         end
         if (owner == 2) begin m_dma_ack = 1'b1; dma_done = 1'b1; end
         else cpu_done = 1'b1;
         owner = 0; m_mem_req = 1'b0;
      end else begin
         waited++;
      end
   endfunction

   // Single compare point per cycle, away from the active edge.
   always @(negedge clk) begin
      logic exp_stall;
      exp_stall = cpu_req && !(owner == 1 && (mem_ready || waited == TIMEOUT - 1));
      chk1 ("cyc_mem_req",   mem_req,   m_mem_req);
      chk1 ("cyc_mem_drw",   mem_drw,   a_drw);
      chk32("cyc_mem_addr",  mem_addr,  a_addr);
      chk32("cyc_mem_wdata", mem_wdata, a_wdata);
      chk32("cyc_cpu_rdata", cpu_rdata, m_cpu_rdata);
      chk32("cyc_dma_rdata", dma_rdata, m_dma_rdata);
      chk1 ("cyc_dma_ack",   dma_ack,   m_dma_ack);
      chk1 ("cyc_err",       err,       m_err);
      chk1 ("cyc_cpu_stall", cpu_stall, exp_stall);
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic drive_random(input int c);
      if (!cpu_req || cpu_done) begin
         cpu_req   = ($urandom_range(0, 3) != 0);
         cpu_drw   = 1'($urandom_range(0, 1));
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
      end
      if (!dma_req || dma_done) begin
         dma_req   = ($urandom_range(0, 2) == 0);
         dma_drw   = 1'($urandom_range(0, 1));
         dma_addr  = $urandom;
         dma_wdata = $urandom;
      end
      if (((c / 500) % 2) == 1)
         mem_ready = ($urandom_range(0, 24) == 0);
      else
         mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
   endtask

   initial begin
      model_reset();
      rst = 1'b0;
      cpu_req = 0; cpu_drw = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_drw = 0; dma_addr = '0; dma_wdata = '0;
      mem_ready = 0; mem_rdata = '0;
      repeat (2) cycle();
      chk1 ("rst_mem_req", mem_req, 1'b0);
      chk1 ("rst_err", err, 1'b0);
      chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
      chk1 ("rst_dma_ack", dma_ack, 1'b0);
      rst = 1'b1;

      // CPU read alone, ready on first grant cycle
      cpu_req = 1; cpu_drw = 0; cpu_addr = 32'h1000_0004;
      #1 chk1("t1_stall_idle", cpu_stall, 1'b1);
      cycle();
      chk1 ("t1_mem_req", mem_req, 1'b1);
      chk32("t1_mem_addr", mem_addr, 32'h1000_0004);
      mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
      #1 chk1("t1_stall_release", cpu_stall, 1'b0);
      cycle();
      chk32("t1_cpu_rdata", cpu_rdata, 32'hCAFE_F00D);
      chk1 ("t1_mem_req_drop", mem_req, 1'b0);
      cpu_req = 0; mem_ready = 0; mem_rdata = '0;

      // DMA write, ready on 3rd grant cycle
      dma_req = 1; dma_drw = 1; dma_addr = 32'h1000_0010; dma_wdata = 32'h1234_5678;
      cycle();
      for (int i = 0; i < 3; i++) begin
         chk1 ("t2_mem_req", mem_req, 1'b1);
         chk1 ("t2_mem_drw", mem_drw, 1'b1);
         chk32("t2_mem_addr", mem_addr, 32'h1000_0010);
         chk32("t2_mem_wdata", mem_wdata, 32'h1234_5678);
         chk1 ("t2_ack_early", dma_ack, 1'b0);
         mem_ready = (i == 2);
         mem_rdata = 32'hDEAD_BEEF;
         cycle();
      end
      chk1 ("t2_ack", dma_ack, 1'b1);
      chk32("t2_dma_rdata", dma_rdata, 32'h0);
      chk1 ("t2_mem_req_drop", mem_req, 1'b0);
      dma_req = 0; mem_ready = 0;
      cycle();
      chk1("t2_ack_single", dma_ack, 1'b0);

      // Ready on the last allowed cycle is a normal completion
      cpu_req = 1; cpu_drw = 0; cpu_addr = 32'h0000_0020;
      cycle();
      for (int i = 1; i <= TIMEOUT; i++) begin
         mem_ready = (i == TIMEOUT); mem_rdata = 32'h0BAD_BEEF;
         #1 chk1("t4b_stall", cpu_stall, (i == TIMEOUT) ? 1'b0 : 1'b1);
         cycle();
      end
      chk1 ("t4b_err", err, 1'b0);
      chk32("t4b_cpu_rdata", cpu_rdata, 32'h0BAD_BEEF);
      cpu_req = 0; mem_ready = 0;

      // Timeout abort
      cpu_req = 1; cpu_addr = 32'h0000_0024;
      cycle();
      for (int i = 1; i <= TIMEOUT; i++) begin
         #1 chk1("t4a_stall", cpu_stall, (i == TIMEOUT) ? 1'b0 : 1'b1);
         chk1("t4a_err_pre", err, 1'b0);
         cycle();
      end
      chk1 ("t4a_err", err, 1'b1);
      chk32("t4a_cpu_rdata", cpu_rdata, 32'h0);
      chk1 ("t4a_mem_req", mem_req, 1'b0);
      cpu_req = 0;

      // Next request still served, err sticky
      dma_req = 1; dma_drw = 0; dma_addr = 32'h0000_0030;
      cycle();
      mem_ready = 1; mem_rdata = 32'h55AA_55AA;
      cycle();
      chk1 ("t4a_next_ack", dma_ack, 1'b1);
      chk32("t4a_next_rdata", dma_rdata, 32'h55AA_55AA);
      chk1 ("t4a_err_sticky", err, 1'b1);
      dma_req = 0; mem_ready = 0;
      cycle();

      // Asynchronous reset during a DMA grant
      dma_req = 1; dma_drw = 1; dma_addr = 32'h0000_0040; dma_wdata = 32'h7777_0000;
      cycle();
      chk1("t5_granted", mem_req, 1'b1);
      #1 rst = 1'b0;
      model_reset();
      #1;
      chk1("t5_mem_req", mem_req, 1'b0);
      chk1("t5_dma_ack", dma_ack, 1'b0);
      chk1("t5_err", err, 1'b0);
      dma_req = 0;
      cycle();
      rst = 1'b1;

      // Continuous contention after reset: CPU, DMA, CPU, DMA
      cpu_req = 1; cpu_drw = 0; cpu_addr = 32'h0000_0100;
      dma_req = 1; dma_drw = 0; dma_addr = 32'h0000_0200;
      mem_ready = 1;
      for (int i = 1; i <= 8; i++) begin
         cycle();
         if (i % 2 == 1) begin
            chk1 ("t3_mem_req", mem_req, 1'b1);
            chk32("t3_order", mem_addr, (i % 4 == 1) ? 32'h0000_0100 : 32'h0000_0200);
         end else begin
            chk1("t3_bubble", mem_req, 1'b0);
         end
      end
      cpu_req = 0; dma_req = 0; mem_ready = 0;
      cycle();

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         cycle();
         drive_random(c);
      end
      cpu_req = 0; dma_req = 0;
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
